muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide engine, consumed by the Execute stage.
- Execute raises `isMulE` for M-extension ops and holds the pipeline until this block returns `done`, which feeds the HazardUnit's `isDone`.
- Covers MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU, selected by funct3.
- Multiply uses a shift-add datapath; divide uses restoring division.

---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/udiv_step.sv | 26 ++
 rtl/muldiv_unit.sv | 165 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide engine.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_t;

  // Wide enough to be truncated to any supported DATA_WIDTH.
  localparam logic [63:0] DIV0_QUOT = '1;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

endpackage

// File: rtl/udiv_step.sv
// One restoring-division iteration: shift {rem, quot} left, subtract divisor if it fits.
module udiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quot_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quot_o
);

  logic [WIDTH:0] rem_sh;

  always_comb begin
    rem_sh = {rem_i, quot_i[WIDTH-1]};
    if (rem_sh >= {1'b0, divisor_i}) begin
      // Difference is below the divisor, so the low WIDTH bits are exact.
      rem_o  = rem_sh[WIDTH-1:0] - divisor_i;
      quot_o = {quot_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o  = rem_sh[WIDTH-1:0];
      quot_o = {quot_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (shift-add multiply, restoring divide).
// Optional MULDIV_FAST_MUL_EN: multiplies complete combinationally in one cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  kill,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] opA,
  input  logic [DATA_WIDTH-1:0] opB,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int unsigned W = DATA_WIDTH;

  muldiv_state_t    state_q, state_d;
  muldiv_op_t       op_q, op_d;
  logic [W-1:0]     mcand_q, mcand_d;   // multiplicand, or divisor
  logic [W-1:0]     mplr_q, mplr_d;     // multiplier, or dividend/quotient
  logic [2*W-1:0]   acc_q, acc_d;       // product, or remainder in low half
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic             div0_q, div0_d;
  logic [W-1:0]     result_q, result_d;

  muldiv_op_t   in_op;
  logic         a_neg, b_neg, in_neg, in_div0;
  logic [W-1:0] a_abs, b_abs;
  logic [W-1:0] div_rem, div_quot;
  logic [W:0]   mul_sum;
  logic [2*W-1:0] mul_acc;

  muldiv_op_t     fin_op;
  logic           fin_neg, fin_div0;
  logic [2*W-1:0] fin_acc, fin_prod;
  logic [W-1:0]   fin_quot, fin_q_fix, fin_r_fix, fin_res;

  always_comb begin
    in_op   = muldiv_op_t'(funct3);
    a_neg   = opA[W-1] && (in_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    b_neg   = opB[W-1] && (in_op inside {OP_MULH, OP_DIV, OP_REM});
    a_abs   = a_neg ? -opA : opA;
    b_abs   = b_neg ? -opB : opB;
    in_neg  = (in_op == OP_REM) ? a_neg : (a_neg ^ b_neg);
    in_div0 = funct3[2] && (opB == '0);
  end

  udiv_step #(.WIDTH(W)) u_step (
    .rem_i     (acc_q[W-1:0]),
    .quot_i    (mplr_q),
    .divisor_i (mcand_q),
    .rem_o     (div_rem),
    .quot_o    (div_quot)
  );

  always_comb begin
    mul_sum = {1'b0, acc_q[2*W-1:W]} + (mplr_q[0] ? {1'b0, mcand_q} : '0);
    mul_acc = {mul_sum, acc_q[W-1:1]};
  end

  // Sources for the final result: the last iteration's next values, or the inputs directly.
  always_comb begin
    fin_op   = op_q;
    fin_neg  = neg_q;
    fin_div0 = div0_q;
    fin_acc  = op_q[2] ? {{W{1'b0}}, div_rem} : mul_acc;
    fin_quot = div_quot;
`ifdef MULDIV_FAST_MUL_EN
    if (state_q != ST_RUN) begin
      fin_op   = in_op;
      fin_neg  = in_neg;
      fin_div0 = 1'b0;
      fin_acc  = (2*W)'(a_abs) * (2*W)'(b_abs);
    end
`endif
  end

  always_comb begin
    fin_prod  = fin_neg ? -fin_acc : fin_acc;
    fin_q_fix = fin_div0 ? W'(DIV0_QUOT) : (fin_neg ? -fin_quot : fin_quot);
    fin_r_fix = fin_neg ? -fin_acc[W-1:0] : fin_acc[W-1:0];
    case (fin_op)
      OP_MUL:                      fin_res = fin_prod[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fin_res = fin_prod[2*W-1:W];
      OP_DIV, OP_DIVU:             fin_res = fin_q_fix;
      default:                     fin_res = fin_r_fix;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mcand_d  = mcand_q;
    mplr_d   = mplr_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    div0_d   = div0_q;
    result_d = result_q;
    if (kill) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_RUN) begin
      acc_d  = op_q[2] ? {{W{1'b0}}, div_rem} : mul_acc;
      mplr_d = op_q[2] ? div_quot : (mplr_q >> 1);
      cnt_d  = cnt_q + 1'b1;
      if (cnt_q == CNT_WIDTH'(W - 1)) begin
        state_d  = ST_DONE;
        result_d = fin_res;
      end
    end else if (start) begin
      op_d    = in_op;
      mcand_d = funct3[2] ? b_abs : a_abs;
      mplr_d  = funct3[2] ? a_abs : b_abs;
      acc_d   = '0;
      cnt_d   = '0;
      neg_d   = in_neg;
      div0_d  = in_div0;
      state_d = ST_RUN;
`ifdef MULDIV_FAST_MUL_EN
      if (!funct3[2]) begin
        state_d  = ST_DONE;
        result_d = fin_res;
      end
`endif
    end else begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MUL;
      mcand_q  <= '0;
      mplr_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      div0_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      mplr_q   <= mplr_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      div0_q   <= div0_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == ST_RUN);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit; honours MULDIV_FAST_MUL_EN for multiply latency.
module tb_muldiv_unit;
  import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        rst, start, kill;
  logic [2:0]  funct3;
  logic [31:0] opA, opB;
  logic        busy, done;
  logic [31:0] result;

  int unsigned total = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .kill   (kill),
    .funct3 (funct3),
    .opA    (opA),
    .opB    (opB),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat_exp, input string tag);
    int lat;
    int busy_n;
    @(negedge clk);
    funct3 = f; opA = a; opB = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    opA = $urandom(); opB = $urandom(); funct3 = 3'($urandom_range(0, 7));
    lat = 1; busy_n = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) busy_n++;
      @(negedge clk);
      lat++;
    end
    chk(32'(lat), 32'(lat_exp), {tag, "_lat"});
    chk(result, exp, {tag, "_res"});
    chk(32'(busy_n), 32'(lat_exp - 1), {tag, "_busy"});
    @(negedge clk);
    chk({31'b0, done}, 32'd0, {tag, "_pulse"});
  endtask

  initial begin
    int lat;
    int done_n;
    rst = 1'b1; start = 1'b0; kill = 1'b0; funct3 = 3'd0; opA = '0; opB = '0;
    repeat (3) @(negedge clk);
    chk({31'b0, busy}, 32'd0, "rst_busy");
    chk({31'b0, done}, 32'd0, "rst_done");
    chk(result, 32'd0, "rst_result");
    rst = 1'b0;

    do_op(3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, "mul_7x-3");
    do_op(3'b001, INT_MIN,      INT_MIN,       32'h4000_0000, MUL_LAT, "mulh_min");
    do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, "mulhu_ff");
    do_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, "mulhsu_ff");
    do_op(3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, DIV_LAT, "div_-7_2");
    do_op(3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, DIV_LAT, "rem_-7_2");
    do_op(3'b101, 32'd100,      32'd7,         32'd14,        DIV_LAT, "divu_100_7");
    do_op(3'b111, 32'd100,      32'd7,         32'd2,         DIV_LAT, "remu_100_7");
    do_op(3'b101, 32'd5,        32'd0,         32'hFFFF_FFFF, DIV_LAT, "divu_by0");
    do_op(3'b110, 32'd5,        32'd0,         32'd5,         DIV_LAT, "rem_by0");
    do_op(3'b100, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFFF, DIV_LAT, "div_neg_by0");
    do_op(3'b110, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, DIV_LAT, "rem_neg_by0");
    do_op(3'b100, INT_MIN,      32'hFFFF_FFFF, INT_MIN,       DIV_LAT, "div_ovf");
    do_op(3'b110, INT_MIN,      32'hFFFF_FFFF, 32'd0,         DIV_LAT, "rem_ovf");
    do_op(3'b000, 32'd6,        32'd7,         32'd42,        MUL_LAT, "mul_6x7");

    // kill at cycle 10 of a divide: no completion, result keeps 42
    @(negedge clk);
    funct3 = 3'b101; opA = 32'd1000; opB = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk({31'b0, busy}, 32'd1, "kill_busy_before");
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk({31'b0, busy}, 32'd0, "kill_busy_after");
    chk({31'b0, done}, 32'd0, "kill_done_after");
    chk(result, 32'd42, "kill_result_held");
    done_n = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) done_n++;
    end
    chk(32'(done_n), 32'd0, "kill_no_done");
    chk(result, 32'd42, "kill_result_final");

    // reset at cycle 10 of a divide: everything back to zero
    @(negedge clk);
    funct3 = 3'b101; opA = 32'd1000; opB = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk({31'b0, busy}, 32'd0, "rst_mid_busy");
    chk(result, 32'd0, "rst_mid_result");
    done_n = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) done_n++;
    end
    chk(32'(done_n), 32'd0, "rst_mid_no_done");

    // back-to-back: start held high; funct3 switched to REMU during RUN is only taken at the done edge
    @(negedge clk);
    funct3 = 3'b101; opA = 32'd100; opB = 32'd7; start = 1'b1;
    @(negedge clk);
    funct3 = 3'b111;
    lat = 1;
    chk({31'b0, busy}, 32'd1, "b2b_busy1");
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk(32'(lat), 32'd33, "b2b_lat1");
    chk(result, 32'd14, "b2b_res1");
    @(negedge clk);
    start = 1'b0;
    chk({31'b0, done}, 32'd0, "b2b_pulse1");
    chk({31'b0, busy}, 32'd1, "b2b_accept2");
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk(32'(lat), 32'd33, "b2b_lat2");
    chk(result, 32'd2, "b2b_res2");
    @(negedge clk);
    chk({31'b0, done}, 32'd0, "b2b_pulse2");

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
